// File: rtl/i2c_rx_word_ctrl.sv
// i2c_rx_word_ctrl
//   Receive-side sequencer for the serial-in word buffer (8/16/32-bit,
//   LSB-first). Counts sampled bits per word, issues one shift-load strobe per
//   accepted bit, keeps a shadow copy of the word and hands it upstream with a
//   valid/ack handshake.
//
// Ports
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   start      frame start / repeated start pulse
//   stop       frame stop pulse
//   size       word size (8, 16 or 32), latched on an accepted start
//   bit_stb    din holds a valid sampled bit
//   din        sampled serial bit
//   rload      shift-load strobe to the buffer, one cycle per accepted bit
//   din_q      accepted bit, aligned with rload
//   bit_cnt    bits accepted in the current word
//   busy       high in SHIFT or HOLD
//   word_valid rdata holds a complete word
//   word_ack   consumer takes rdata
//   rdata      shadow word, right-justified, upper bits zero
//   overrun    sticky: a bit or a whole word was lost
//   size_err   one-cycle pulse: start seen with an illegal size
//
// State table
//   state   | meaning
//   S_IDLE  | no frame open; bits and acks ignored
//   S_SHIFT | collecting bits of the current word
//   S_HOLD  | complete word waiting for word_ack; new bits are dropped
//
// Per-cycle priority: rst > stop > start > bit_stb.

module i2c_rx_word_ctrl #(
  parameter int MAXW = 32,
  parameter int CNTW = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic [7:0]      size,
  input  logic            bit_stb,
  input  logic            din,
  output logic            rload,
  output logic            din_q,
  output logic [CNTW-1:0] bit_cnt,
  output logic            busy,
  output logic            word_valid,
  input  logic            word_ack,
  output logic [MAXW-1:0] rdata,
  output logic            overrun,
  output logic            size_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]      state, state_n;
  logic [CNTW-1:0] size_q, size_n;
  logic [CNTW-1:0] cnt_n, cnt_inc;
  logic [MAXW-1:0] rdata_n;
  logic            stop_seen, stop_seen_n;
  logic            rload_n, din_q_n, valid_n, ovr_n, serr_n;
  logic            size_ok, restart, dropped;

  // New bit enters at the top of the latched width and everything moves down,
  // so after size bits the first bit sits at bit 0 - same as the buffer.
  function automatic logic [MAXW-1:0] shift_in(input logic [MAXW-1:0] cur,
                                               input logic            b,
                                               input logic [CNTW-1:0] w);
    logic [MAXW-1:0] r;
    r = cur >> 1;
    case (w)
      CNTW'(8):  r[7]      = b;
      CNTW'(16): r[15]     = b;
      default:   r[MAXW-1] = b;
    endcase
    return r;
  endfunction

  assign size_ok = (size == 8'd8) || (size == 8'd16) || (size == 8'd32);
  assign cnt_inc = bit_cnt + 1'b1;
  assign busy    = (state != S_IDLE);

  // A start while busy behaves as stop+start in one cycle. Only an unacked
  // word in HOLD counts as lost data; a partial word in SHIFT does not.
  assign restart = busy && !stop && start;
  assign dropped = (state == S_HOLD) && !word_ack;

  always_comb begin
    state_n     = state;
    size_n      = size_q;
    cnt_n       = bit_cnt;
    rdata_n     = rdata;
    valid_n     = word_valid;
    ovr_n       = overrun;
    serr_n      = 1'b0;
    rload_n     = 1'b0;
    din_q_n     = din_q;
    stop_seen_n = stop_seen;

    if (restart) begin
      cnt_n       = '0;
      rdata_n     = '0;
      valid_n     = 1'b0;
      stop_seen_n = 1'b0;
      if (size_ok) begin
        size_n  = size[CNTW-1:0];
        ovr_n   = dropped;
        state_n = S_SHIFT;
      end else begin
        serr_n  = 1'b1;
        ovr_n   = overrun | dropped;
        state_n = S_IDLE;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !stop) begin
            if (size_ok) begin
              size_n  = size[CNTW-1:0];
              cnt_n   = '0;
              rdata_n = '0;
              ovr_n   = 1'b0;
              state_n = S_SHIFT;
            end else begin
              serr_n = 1'b1;
            end
          end
        end

        S_SHIFT: begin
          if (stop) begin
            cnt_n   = '0;
            rdata_n = '0;
            state_n = S_IDLE;
          end else if (bit_stb) begin
            rload_n = 1'b1;
            din_q_n = din;
            cnt_n   = cnt_inc;
            rdata_n = shift_in(rdata, din, size_q);
            if (cnt_inc == size_q) begin
              valid_n = 1'b1;
              state_n = S_HOLD;
            end
          end
        end

        S_HOLD: begin
          if (stop) begin
            // Stop arriving together with the ack closes the frame right away.
            if (word_ack) begin
              valid_n     = 1'b0;
              cnt_n       = '0;
              rdata_n     = '0;
              stop_seen_n = 1'b0;
              state_n     = S_IDLE;
            end else begin
              stop_seen_n = 1'b1;
            end
          end else if (word_ack) begin
            valid_n = 1'b0;
            cnt_n   = '0;
            rdata_n = '0;
            if (stop_seen) begin
              stop_seen_n = 1'b0;
              state_n     = S_IDLE;
            end else begin
              state_n = S_SHIFT;
              // Bit arriving with the ack is the first bit of the next word.
              if (bit_stb) begin
                rload_n = 1'b1;
                din_q_n = din;
                cnt_n   = CNTW'(1);
                rdata_n = shift_in('0, din, size_q);
              end
            end
          end else if (bit_stb) begin
            ovr_n = 1'b1;
          end
        end

        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      size_q     <= CNTW'(8);
      bit_cnt    <= '0;
      rdata      <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
      size_err   <= 1'b0;
      rload      <= 1'b0;
      din_q      <= 1'b0;
      stop_seen  <= 1'b0;
    end else begin
      state      <= state_n;
      size_q     <= size_n;
      bit_cnt    <= cnt_n;
      rdata      <= rdata_n;
      word_valid <= valid_n;
      overrun    <= ovr_n;
      size_err   <= serr_n;
      rload      <= rload_n;
      din_q      <= din_q_n;
      stop_seen  <= stop_seen_n;
    end
  end

endmodule

// File: tb/tb_i2c_rx_word_ctrl.sv
// Testbench for i2c_rx_word_ctrl: a table of single-cycle vectors for the
// IDLE/start/stop/size handling, then hand-written sequences for complete
// words, handshake corner cases and reset. Accepted bits and completed words
// are pushed to scoreboard queues when driven and checked when the DUT
// raises rload / word_valid.

module tb_i2c_rx_word_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, stop, bit_stb, din, word_ack;
  logic [7:0]  size;
  logic        rload, din_q, busy, word_valid, overrun, size_err;
  logic [5:0]  bit_cnt;
  logic [31:0] rdata;

  int n_vec = 0;
  int n_err = 0;
  int rl_cnt = 0;

  logic        bq[$];
  logic [31:0] wq[$];
  logic        wv_prev = 1'b0;
  logic        exp_b;
  logic [31:0] exp_w;

  typedef struct {
    logic       st, sp;
    logic [7:0] sz;
    logic       bs, d, ak;
    logic       busy_e, serr_e;
    logic [5:0] cnt_e;
    logic       rl_e;
    logic [31:0] rd_e;
  } vec_t;

  vec_t tbl[$];

  i2c_rx_word_ctrl #(.MAXW(32), .CNTW(6)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .size(size),
    .bit_stb(bit_stb), .din(din), .rload(rload), .din_q(din_q),
    .bit_cnt(bit_cnt), .busy(busy), .word_valid(word_valid),
    .word_ack(word_ack), .rdata(rdata), .overrun(overrun), .size_err(size_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard side: every rload must match a bit the bench expected to be
  // accepted, every new word_valid must match an expected word.
  always @(negedge clk) begin
    if (rload) begin
      rl_cnt++;
      if (bq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rload: got rload=1 expected no accepted bit");
      end else begin
        exp_b = bq.pop_front();
        chk("din_q", 32'(din_q), 32'(exp_b));
      end
    end
    if (word_valid && !wv_prev) begin
      if (wq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got rdata=%h expected no word", rdata);
      end else begin
        exp_w = wq.pop_front();
        chk("word_rdata", rdata, exp_w);
      end
    end
    wv_prev = word_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start = 1'b0; stop = 1'b0; bit_stb = 1'b0; din = 1'b0; word_ack = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic acc);
    bit_stb = 1'b1;
    din     = b;
    if (acc) bq.push_back(b);
    step();
    bit_stb = 1'b0;
    din     = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int n);
    wq.push_back(w);
    for (int i = 0; i < n; i++) send_bit(w[i], 1'b1);
  endtask

  task automatic do_start(input logic [7:0] sz);
    start = 1'b1;
    size  = sz;
    step();
    start = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rload"},    32'(rload),      32'd0);
    chk({tag, "_din_q"},    32'(din_q),      32'd0);
    chk({tag, "_bit_cnt"},  32'(bit_cnt),    32'd0);
    chk({tag, "_busy"},     32'(busy),       32'd0);
    chk({tag, "_valid"},    32'(word_valid), 32'd0);
    chk({tag, "_rdata"},    rdata,           32'd0);
    chk({tag, "_overrun"},  32'(overrun),    32'd0);
    chk({tag, "_size_err"}, 32'(size_err),   32'd0);
  endtask

  task automatic add(input logic st, input logic sp, input logic [7:0] sz,
                     input logic bs, input logic d, input logic ak,
                     input logic busy_e, input logic serr_e,
                     input logic [5:0] cnt_e, input logic rl_e,
                     input logic [31:0] rd_e);
    vec_t v;
    v.st = st; v.sp = sp; v.sz = sz; v.bs = bs; v.d = d; v.ak = ak;
    v.busy_e = busy_e; v.serr_e = serr_e; v.cnt_e = cnt_e; v.rl_e = rl_e; v.rd_e = rd_e;
    tbl.push_back(v);
  endtask

  initial begin
    //   st    sp    size   bs    d     ak     busy  serr  cnt    rl    rdata
    add(1'b1, 1'b0, 8'd12, 1'b0, 1'b0, 1'b0,  1'b0, 1'b1, 6'd0, 1'b0, 32'h0);      // illegal size
    add(1'b0, 1'b0, 8'd12, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
    add(1'b0, 1'b0, 8'd8,  1'b1, 1'b1, 1'b0,  1'b0, 1'b0, 6'd0, 1'b0, 32'h0);      // bit in IDLE
    add(1'b0, 1'b0, 8'd8,  1'b0, 1'b0, 1'b1,  1'b0, 1'b0, 6'd0, 1'b0, 32'h0);      // ack in IDLE
    add(1'b1, 1'b0, 8'd16, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 6'd0, 1'b0, 32'h0);      // start 16
    add(1'b0, 1'b0, 8'd16, 1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 6'd1, 1'b1, 32'h8000);
    add(1'b0, 1'b0, 8'd16, 1'b1, 1'b0, 1'b0,  1'b1, 1'b0, 6'd2, 1'b1, 32'h4000);
    add(1'b0, 1'b0, 8'd16, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 6'd2, 1'b0, 32'h4000);
    add(1'b0, 1'b0, 8'd16, 1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 6'd3, 1'b1, 32'hA000);
    add(1'b0, 1'b0, 8'd8,  1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 6'd4, 1'b1, 32'hD000);   // size change ignored
    add(1'b0, 1'b1, 8'd8,  1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 6'd0, 1'b0, 32'h0);      // stop mid-word
    add(1'b1, 1'b1, 8'd8,  1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 6'd0, 1'b0, 32'h0);      // start+stop
    add(1'b1, 1'b0, 8'd8,  1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 6'd0, 1'b0, 32'h0);
    add(1'b0, 1'b0, 8'd8,  1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 6'd1, 1'b1, 32'h80);
    add(1'b0, 1'b0, 8'd8,  1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 6'd2, 1'b1, 32'hC0);
    add(1'b0, 1'b0, 8'd8,  1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 6'd3, 1'b1, 32'hE0);
    add(1'b0, 1'b0, 8'd8,  1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 6'd4, 1'b1, 32'hF0);
    add(1'b0, 1'b0, 8'd8,  1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 6'd5, 1'b1, 32'hF8);
    add(1'b0, 1'b1, 8'd8,  1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 6'd0, 1'b0, 32'h0);      // stop after 5 of 8
    add(1'b1, 1'b0, 8'd32, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 6'd0, 1'b0, 32'h0);
    add(1'b1, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0,  1'b0, 1'b1, 6'd0, 1'b0, 32'h0);      // illegal repeated start

    rst = 1'b1; size = 8'd0; idle_in();
    step(); step();
    chk_zero("reset");
    rst = 1'b0;

    foreach (tbl[i]) begin
      start = tbl[i].st; stop = tbl[i].sp; size = tbl[i].sz;
      bit_stb = tbl[i].bs; din = tbl[i].d; word_ack = tbl[i].ak;
      if (tbl[i].rl_e) bq.push_back(tbl[i].d);
      step();
      chk($sformatf("v%0d_busy", i),     32'(busy),       32'(tbl[i].busy_e));
      chk($sformatf("v%0d_size_err", i), 32'(size_err),   32'(tbl[i].serr_e));
      chk($sformatf("v%0d_bit_cnt", i),  32'(bit_cnt),    32'(tbl[i].cnt_e));
      chk($sformatf("v%0d_rload", i),    32'(rload),      32'(tbl[i].rl_e));
      chk($sformatf("v%0d_rdata", i),    rdata,           tbl[i].rd_e);
      chk($sformatf("v%0d_valid", i),    32'(word_valid), 32'd0);
      idle_in();
    end

    // 8-bit word with idle gaps, then ack
    rst = 1'b1; step(); rst = 1'b0;
    rl_cnt = 0;
    do_start(8'd8);
    begin
      logic [7:0] w8;
      w8 = 8'h4D;
      wq.push_back(32'h4D);
      for (int i = 0; i < 8; i++) begin
        send_bit(w8[i], 1'b1);
        chk($sformatf("w8_cnt%0d", i), 32'(bit_cnt), 32'(i + 1));
        chk($sformatf("w8_valid%0d", i), 32'(word_valid), (i == 7) ? 32'd1 : 32'd0);
        if (i != 7) step();
      end
    end
    chk("w8_rdata", rdata, 32'h4D);
    step();
    chk("w8_rload_cnt", 32'(rl_cnt), 32'd8);
    chk("w8_hold_rload", 32'(rload), 32'd0);
    word_ack = 1'b1; step(); word_ack = 1'b0;
    chk("w8_ack_valid", 32'(word_valid), 32'd0);
    chk("w8_ack_cnt", 32'(bit_cnt), 32'd0);
    chk("w8_ack_busy", 32'(busy), 32'd1);

    // 32-bit word, ack together with the next bit
    do_start(8'd32);
    chk("w32_start_cnt", 32'(bit_cnt), 32'd0);
    send_word(32'hDEADBEEF, 32);
    chk("w32_valid", 32'(word_valid), 32'd1);
    chk("w32_rdata", rdata, 32'hDEADBEEF);
    word_ack = 1'b1; bit_stb = 1'b1; din = 1'b1; bq.push_back(1'b1);
    step(); idle_in();
    chk("w32_next_cnt", 32'(bit_cnt), 32'd1);
    chk("w32_next_rload", 32'(rload), 32'd1);
    chk("w32_next_valid", 32'(word_valid), 32'd0);
    chk("w32_next_overrun", 32'(overrun), 32'd0);
    chk("w32_next_rdata", rdata, 32'h80000000);

    // 16-bit word, bits lost while holding
    do_start(8'd16);
    send_word(32'h1234, 16);
    chk("w16_valid", 32'(word_valid), 32'd1);
    for (int i = 0; i < 2; i++) begin
      send_bit(1'b1, 1'b0);
      chk($sformatf("w16_drop_rload%0d", i), 32'(rload), 32'd0);
    end
    chk("w16_overrun", 32'(overrun), 32'd1);
    chk("w16_rdata_kept", rdata, 32'h1234);
    chk("w16_cnt_kept", 32'(bit_cnt), 32'd16);
    word_ack = 1'b1; step(); word_ack = 1'b0;
    chk("w16_ack_cnt", 32'(bit_cnt), 32'd0);
    chk("w16_ack_busy", 32'(busy), 32'd1);
    chk("w16_ack_overrun", 32'(overrun), 32'd1);
    do_start(8'd8);
    chk("restart_clears_ovr", 32'(overrun), 32'd0);

    // repeated start drops an unacked word
    send_word(32'hA5, 8);
    do_start(8'd8);
    chk("rs_drop_valid", 32'(word_valid), 32'd0);
    chk("rs_drop_overrun", 32'(overrun), 32'd1);
    chk("rs_drop_busy", 32'(busy), 32'd1);

    // stop during HOLD keeps the word until ack
    do_start(8'd8);
    send_word(32'h3C, 8);
    stop = 1'b1; step(); stop = 1'b0;
    chk("hstop_valid", 32'(word_valid), 32'd1);
    chk("hstop_busy", 32'(busy), 32'd1);
    chk("hstop_rdata", rdata, 32'h3C);
    word_ack = 1'b1; step(); word_ack = 1'b0;
    chk("hstop_ack_busy", 32'(busy), 32'd0);
    chk("hstop_ack_valid", 32'(word_valid), 32'd0);

    // reset mid-word with overrun set, then reset in HOLD
    do_start(8'd8);
    send_word(32'h81, 8);
    send_bit(1'b0, 1'b0);
    word_ack = 1'b1; step(); word_ack = 1'b0;
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1);
    chk("mid_cnt", 32'(bit_cnt), 32'd3);
    chk("mid_overrun", 32'(overrun), 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    chk_zero("rst_mid");
    do_start(8'd8);
    send_word(32'h7E, 8);
    chk("hold_valid", 32'(word_valid), 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    chk_zero("rst_hold");

    step(); step();
    chk("bits_left", 32'(bq.size()), 32'd0);
    chk("words_left", 32'(wq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
